// File: rtl/spi_reg_config_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_config_if
// Brief    : SPI pin bundle (SCLK, COPI, nCS, CIPO) between master and target.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_reg_config_if;
    logic sclk;
    logic copi;
    logic ncs;
    logic cipo;

    modport master (
        output sclk,
        output copi,
        output ncs,
        input  cipo
    );

    modport slave (
        input  sclk,
        input  copi,
        input  ncs,
        output cipo
    );
endinterface
`default_nettype wire

// File: rtl/spi_reg_config.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_config
// Brief    : Mode-0 SPI target owning the PWM peripheral configuration
//            registers. Optional register readback on CIPO: SPI_READBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_config #(
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    spi_reg_config_if.slave   spi,
    output logic [7:0]        en_reg_out_7_0,
    output logic [7:0]        en_reg_out_15_8,
    output logic [7:0]        en_reg_pwm_7_0,
    output logic [7:0]        en_reg_pwm_15_8,
    output logic [7:0]        pwm_duty_cycle,
    output logic              wr_strobe
);

    localparam logic [7:0] c_NUM_REGS  = 8'(NUM_REGS);
    localparam logic [4:0] c_FRAME_LEN = 5'd16;
    localparam logic [4:0] c_CNT_SAT   = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t                  r_state;
    logic [SYNC_STAGES-1:0]  r_sclk_sync;
    logic [SYNC_STAGES-1:0]  r_ncs_sync;
    logic [SYNC_STAGES-1:0]  r_copi_sync;
    logic                    r_sclk_prev;
    logic                    r_ncs_prev;
    logic [SYNC_STAGES:0]    r_sync_vld;
    logic [4:0]              r_cnt;
    logic [15:0]             r_shift;
    logic [7:0]              r_regs [NUM_REGS];
    logic                    r_wr_strobe;

    logic w_sclk;
    logic w_ncs;
    logic w_copi;
    logic w_vld;
    logic w_sclk_rise;
    logic w_ncs_rise;
    logic w_ncs_fall;
    logic [6:0] w_addr;
    logic w_commit_ok;

    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_ncs  = r_ncs_sync[SYNC_STAGES-1];
    assign w_copi = r_copi_sync[SYNC_STAGES-1];

    // Edges are only trusted once every synchroniser stage holds a real pin
    // sample; otherwise a reset release with nCS already low looks like a fall.
    assign w_vld       = r_sync_vld[SYNC_STAGES];
    assign w_sclk_rise = w_vld & ~r_sclk_prev & w_sclk;
    assign w_ncs_rise  = w_vld & ~r_ncs_prev & w_ncs;
    assign w_ncs_fall  = w_vld & r_ncs_prev & ~w_ncs;

    assign w_addr      = r_shift[14:8];
    assign w_commit_ok = (r_cnt == c_FRAME_LEN) && r_shift[15] &&
                         ({1'b0, w_addr} < c_NUM_REGS);

`ifdef SPI_READBACK_EN
    logic       w_sclk_fall;
    logic [6:0] w_rd_addr;
    logic [7:0] w_rd_data;
    logic       w_rd_ok;
    logic [7:0] r_rd_sr;
    logic       r_rd_act;
    logic       r_cipo;

    assign w_sclk_fall = w_vld & r_sclk_prev & ~w_sclk;
    // Address is complete on the 8th rising edge, including the bit being shifted in now.
    assign w_rd_addr   = {r_shift[5:0], w_copi};
    assign w_rd_ok     = ~r_shift[6] && ({1'b0, w_rd_addr} < c_NUM_REGS);

    always_comb begin
        w_rd_data = 8'h00;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_rd_addr == 7'(k)) begin
                w_rd_data = r_regs[k];
            end
        end
    end

    assign spi.cipo = r_cipo;
`else
    assign spi.cipo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sclk_sync <= '0;
            r_ncs_sync  <= '1;
            r_copi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_ncs_prev  <= 1'b1;
            r_sync_vld  <= '0;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_wr_strobe <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= 8'h00;
            end
`ifdef SPI_READBACK_EN
            r_rd_sr  <= 8'h00;
            r_rd_act <= 1'b0;
            r_cipo   <= 1'b0;
`endif
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.sclk};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0],  spi.ncs};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], spi.copi};
            r_sclk_prev <= w_sclk;
            r_ncs_prev  <= w_ncs;
            r_sync_vld  <= {r_sync_vld[SYNC_STAGES-1:0], 1'b1};
            r_wr_strobe <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_ncs_fall) begin
                        r_state <= ST_SHIFT;
                        r_cnt   <= '0;
                        r_shift <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (w_ncs_rise) begin
                        r_state <= ST_COMMIT;
                    end else if (w_sclk_rise) begin
                        r_shift <= {r_shift[14:0], w_copi};
                        r_cnt   <= (r_cnt == c_CNT_SAT) ? c_CNT_SAT : r_cnt + 5'd1;
                    end
                end
                ST_COMMIT: begin
                    if (w_commit_ok) begin
                        r_wr_strobe <= 1'b1;
                        for (int k = 0; k < NUM_REGS; k++) begin
                            if (w_addr == 7'(k)) begin
                                r_regs[k] <= r_shift[7:0];
                            end
                        end
                    end
                    if (w_ncs_fall) begin
                        r_state <= ST_SHIFT;
                        r_cnt   <= '0;
                        r_shift <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

`ifdef SPI_READBACK_EN
            if (r_state != ST_SHIFT || w_ncs_rise) begin
                r_rd_act <= 1'b0;
                r_rd_sr  <= 8'h00;
                r_cipo   <= 1'b0;
            end else if (w_sclk_rise && r_cnt == 5'd7) begin
                r_rd_act <= w_rd_ok;
                r_rd_sr  <= w_rd_ok ? w_rd_data : 8'h00;
            end else if (w_sclk_fall && r_rd_act) begin
                r_cipo  <= r_rd_sr[7];
                r_rd_sr <= {r_rd_sr[6:0], 1'b0};
            end
`endif
        end
    end

    logic [7:0] w_out [5];

    for (genvar k = 0; k < 5; k++) begin : g_out
        if (k < NUM_REGS) begin : g_impl
            assign w_out[k] = r_regs[k];
        end else begin : g_none
            assign w_out[k] = 8'h00;
        end
    end

    assign en_reg_out_7_0  = w_out[0];
    assign en_reg_out_15_8 = w_out[1];
    assign en_reg_pwm_7_0  = w_out[2];
    assign en_reg_pwm_15_8 = w_out[3];
    assign pwm_duty_cycle  = w_out[4];
    assign wr_strobe       = r_wr_strobe;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_config.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_reg_config
// Brief    : Directed self-checking bench for spi_reg_config (SPI_READBACK_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_config;

    localparam int c_SYNC = 2;
    localparam int c_HALF = 5;

    logic       clk;
    logic       rst_n;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_strobe;

    int errors;
    int checks;
    int strobe_cnt;
    logic [7:0] rd;

    spi_reg_config_if spi ();

    spi_reg_config #(
        .NUM_REGS    (5),
        .SYNC_STAGES (c_SYNC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .spi             (spi),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .wr_strobe       (wr_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_strobe === 1'b1) strobe_cnt++;
    end

    function automatic logic [39:0] regs_all();
        return {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
                en_reg_pwm_15_8, pwm_duty_cycle};
    endfunction

    // Drives one frame MSB first; rst_at >= 0 pulses rst_n before that bit.
    task automatic spi_xfer(input logic [31:0] bits, input int nbits,
                            input int rst_at, output logic [7:0] rd_o);
        rd_o = 8'h00;
        @(negedge clk);
        spi.ncs = 1'b0;
        repeat (c_HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
            spi.copi = bits[nbits-1-i];
            repeat (c_HALF) @(negedge clk);
            if (i >= 8 && i < 16) rd_o = {rd_o[6:0], spi.cipo};
            spi.sclk = 1'b1;
            repeat (c_HALF) @(negedge clk);
            spi.sclk = 1'b0;
        end
        repeat (c_HALF) @(negedge clk);
        spi.ncs  = 1'b1;
        spi.copi = 1'b0;
    endtask

    task automatic test_reset();
        bit strobe_seen;
        bit cipo_seen;
        strobe_seen = 0;
        cipo_seen   = 0;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        strobe_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr_strobe !== 1'b0) strobe_seen = 1;
            if (spi.cipo !== 1'b0) cipo_seen = 1;
        end
        checks++; if (en_reg_out_7_0 !== 8'h00) begin errors++; $display("FAIL reset_reg0 got=%h exp=00", en_reg_out_7_0); end
        checks++; if (en_reg_out_15_8 !== 8'h00) begin errors++; $display("FAIL reset_reg1 got=%h exp=00", en_reg_out_15_8); end
        checks++; if (en_reg_pwm_7_0 !== 8'h00) begin errors++; $display("FAIL reset_reg2 got=%h exp=00", en_reg_pwm_7_0); end
        checks++; if (en_reg_pwm_15_8 !== 8'h00) begin errors++; $display("FAIL reset_reg3 got=%h exp=00", en_reg_pwm_15_8); end
        checks++; if (pwm_duty_cycle !== 8'h00) begin errors++; $display("FAIL reset_reg4 got=%h exp=00", pwm_duty_cycle); end
        checks++; if (strobe_seen !== 1'b0) begin errors++; $display("FAIL reset_strobe got=%0d exp=0", strobe_seen); end
        checks++; if (cipo_seen !== 1'b0) begin errors++; $display("FAIL reset_cipo got=%0d exp=0", cipo_seen); end
    endtask

    task automatic test_write();
        strobe_cnt = 0;
        spi_xfer(32'h80F0, 16, -1, rd);
        repeat (c_SYNC + 3) @(negedge clk);
        checks++; if (en_reg_out_7_0 !== 8'hF0) begin errors++; $display("FAIL write_reg0 got=%h exp=F0", en_reg_out_7_0); end
        checks++; if (regs_all() !== 40'hF0_00_00_00_00) begin errors++; $display("FAIL write_others got=%h exp=F000000000", regs_all()); end
        repeat (5) @(negedge clk);
        checks++; if (strobe_cnt !== 1) begin errors++; $display("FAIL write_strobe got=%0d exp=1", strobe_cnt); end
    endtask

    task automatic test_back_to_back();
        strobe_cnt = 0;
        spi_xfer(32'h8480, 16, -1, rd);
        repeat (3) @(negedge clk);
        spi_xfer(32'h82FF, 16, -1, rd);
        repeat (10) @(negedge clk);
        checks++; if (pwm_duty_cycle !== 8'h80) begin errors++; $display("FAIL b2b_duty got=%h exp=80", pwm_duty_cycle); end
        checks++; if (en_reg_pwm_7_0 !== 8'hFF) begin errors++; $display("FAIL b2b_pwm0 got=%h exp=FF", en_reg_pwm_7_0); end
        checks++; if (regs_all() !== 40'hF0_00_FF_00_80) begin errors++; $display("FAIL b2b_all got=%h exp=F000FF0080", regs_all()); end
        checks++; if (strobe_cnt !== 2) begin errors++; $display("FAIL b2b_strobe got=%0d exp=2", strobe_cnt); end
    endtask

    task automatic test_invalid();
        logic [7:0] rd_exp;
`ifdef SPI_READBACK_EN
        rd_exp = 8'hF0;
`else
        rd_exp = 8'h00;
`endif
        strobe_cnt = 0;
        spi_xfer(32'h85AA, 16, -1, rd);
        repeat (10) @(negedge clk);
        checks++; if (regs_all() !== 40'hF0_00_FF_00_80) begin errors++; $display("FAIL bad_addr_regs got=%h exp=F000FF0080", regs_all()); end
        checks++; if (strobe_cnt !== 0) begin errors++; $display("FAIL bad_addr_strobe got=%0d exp=0", strobe_cnt); end

        spi_xfer(32'h4055, 15, -1, rd);
        repeat (10) @(negedge clk);
        checks++; if (regs_all() !== 40'hF0_00_FF_00_80) begin errors++; $display("FAIL short_regs got=%h exp=F000FF0080", regs_all()); end
        checks++; if (strobe_cnt !== 0) begin errors++; $display("FAIL short_strobe got=%0d exp=0", strobe_cnt); end

        // Last 16 bits would be a valid write of 0xAA to register 0.
        spi_xfer(32'h080AA, 17, -1, rd);
        repeat (10) @(negedge clk);
        checks++; if (regs_all() !== 40'hF0_00_FF_00_80) begin errors++; $display("FAIL long_regs got=%h exp=F000FF0080", regs_all()); end
        checks++; if (strobe_cnt !== 0) begin errors++; $display("FAIL long_strobe got=%0d exp=0", strobe_cnt); end

        spi_xfer(32'h0055, 16, -1, rd);
        repeat (10) @(negedge clk);
        checks++; if (regs_all() !== 40'hF0_00_FF_00_80) begin errors++; $display("FAIL read_regs got=%h exp=F000FF0080", regs_all()); end
        checks++; if (strobe_cnt !== 0) begin errors++; $display("FAIL read_strobe got=%0d exp=0", strobe_cnt); end
        checks++; if (rd !== rd_exp) begin errors++; $display("FAIL read_cipo got=%h exp=%h", rd, rd_exp); end
    endtask

    task automatic test_reset_midframe();
        strobe_cnt = 0;
        spi_xfer(32'h8133, 16, 9, rd);
        repeat (10) @(negedge clk);
        checks++; if (en_reg_out_15_8 !== 8'h00) begin errors++; $display("FAIL midrst_reg1 got=%h exp=00", en_reg_out_15_8); end
        checks++; if (regs_all() !== 40'h0) begin errors++; $display("FAIL midrst_all got=%h exp=0000000000", regs_all()); end
        checks++; if (strobe_cnt !== 0) begin errors++; $display("FAIL midrst_strobe got=%0d exp=0", strobe_cnt); end
        spi_xfer(32'h8133, 16, -1, rd);
        repeat (10) @(negedge clk);
        checks++; if (en_reg_out_15_8 !== 8'h33) begin errors++; $display("FAIL clean_reg1 got=%h exp=33", en_reg_out_15_8); end
        checks++; if (strobe_cnt !== 1) begin errors++; $display("FAIL clean_strobe got=%0d exp=1", strobe_cnt); end
    endtask

`ifdef SPI_READBACK_EN
    task automatic test_readback();
        spi_xfer(32'h84C3, 16, -1, rd);
        repeat (10) @(negedge clk);
        checks++; if (pwm_duty_cycle !== 8'hC3) begin errors++; $display("FAIL rb_write got=%h exp=C3", pwm_duty_cycle); end
        strobe_cnt = 0;
        spi_xfer(32'h0400, 16, -1, rd);
        repeat (10) @(negedge clk);
        checks++; if (rd !== 8'hC3) begin errors++; $display("FAIL rb_data got=%h exp=C3", rd); end
        checks++; if (regs_all() !== 40'h00_33_00_00_C3) begin errors++; $display("FAIL rb_regs got=%h exp=00330000C3", regs_all()); end
        checks++; if (strobe_cnt !== 0) begin errors++; $display("FAIL rb_strobe got=%0d exp=0", strobe_cnt); end
        checks++; if (spi.cipo !== 1'b0) begin errors++; $display("FAIL rb_idle_cipo got=%b exp=0", spi.cipo); end
    endtask
`endif

    initial begin
        errors     = 0;
        checks     = 0;
        strobe_cnt = 0;
        rst_n      = 1'b0;
        spi.sclk   = 1'b0;
        spi.copi   = 1'b0;
        spi.ncs    = 1'b1;
        test_reset();
        test_write();
        test_back_to_back();
        test_invalid();
        test_reset_midframe();
`ifdef SPI_READBACK_EN
        test_readback();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
